picosoc_gpio: RTL and testbench

- Parametrised GPIO peripheral on the PicoSoC `iomem` bus: NUM_PINS bidirectional channels.
- Per-pin output, output-enable, pull-up and pull-down registers.
- Per-pin input synchroniser and optional debounce filter.
- Per-pin rising/falling edge capture into a sticky interrupt status register, driving one level interrupt into a picosoc `irq_*` input.

---
 rtl/picosoc_gpio_if.sv | 21 ++
 rtl/picosoc_gpio.sv | 162 ++++++++++++++++
 tb/tb_picosoc_gpio.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_gpio_if.sv
// PicoSoC iomem bus bundle for the GPIO peripheral.
// Handshake: the master holds valid and its request fields steady until ready;
// ready is a one-cycle pulse, and rdata is meaningful only while ready is high.
interface picosoc_gpio_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/picosoc_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: pad control registers, synchronised
// and optionally debounced inputs, and sticky edge interrupts merged into one irq.
module picosoc_gpio #(
  parameter int          NUM_PINS        = 8,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter logic [7:0]  BASE_SEL        = 8'h07
) (
  input  logic                clk,
  input  logic                resetn,
  picosoc_gpio_if.slave       bus,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb,
  output logic [NUM_PINS-1:0] gpio_pu,
  output logic [NUM_PINS-1:0] gpio_pd,
  output logic                irq
);

  localparam logic [7:0] A_DATA = 8'h00;
  localparam logic [7:0] A_OEB  = 8'h04;
  localparam logic [7:0] A_PU   = 8'h08;
  localparam logic [7:0] A_PD   = 8'h0C;
  localparam logic [7:0] A_RISE = 8'h10;
  localparam logic [7:0] A_FALL = 8'h14;
  localparam logic [7:0] A_STAT = 8'h18;
  localparam logic [7:0] A_OUT  = 8'h1C;

  logic                ready_q;
  logic [31:0]         rdata_q;
  logic [31:0]         rd_val;
  logic [7:0]          off;
  logic                sel;
  logic                we;
  logic [NUM_PINS-1:0] out_q, oeb_q, pu_q, pd_q, rise_en_q, fall_en_q, status_q;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync;
  logic [NUM_PINS-1:0] filt, filt_d;
  logic [NUM_PINS-1:0] set_ev, clr_ev;
  logic                unused_bits;

  function automatic logic [31:0] ext(input logic [NUM_PINS-1:0] v);
    ext = '0;
    ext[NUM_PINS-1:0] = v;
  endfunction

  // Byte-strobed update; bits above NUM_PINS simply do not exist.
  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0] strb);
    for (int i = 0; i < NUM_PINS; i++)
      merge[i] = strb[i/8] ? data[i] : old[i];
  endfunction

  assign off = bus.iomem_addr[7:0];
  assign sel = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_SEL);
  assign we  = sel && (bus.iomem_wstrb != 4'b0000);

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign unused_bits     = ^{bus.iomem_addr[23:8], bus.iomem_wdata};

  assign gpio_out = out_q;
  assign gpio_oeb = oeb_q;
  assign gpio_pu  = pu_q;
  assign gpio_pd  = pd_q;
  assign irq      = |status_q;

  always_comb begin
    rd_val = '0;
    case (off)
      A_DATA:  rd_val = ext(filt);
      A_OEB:   rd_val = ext(oeb_q);
      A_PU:    rd_val = ext(pu_q);
      A_PD:    rd_val = ext(pd_q);
      A_RISE:  rd_val = ext(rise_en_q);
      A_FALL:  rd_val = ext(fall_en_q);
      A_STAT:  rd_val = ext(status_q);
      A_OUT:   rd_val = ext(out_q);
      default: rd_val = '0;
    endcase
  end

  assign set_ev = (filt & ~filt_d & rise_en_q) | (~filt & filt_d & fall_en_q);
  assign clr_ev = (we && off == A_STAT) ? merge('0, bus.iomem_wdata, bus.iomem_wstrb) : '0;

  // rdata captures the pre-write value, so writes return read-then-write data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      oeb_q     <= '1;
      pu_q      <= '0;
      pd_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      ready_q  <= sel;
      rdata_q  <= sel ? rd_val : '0;
      status_q <= (status_q & ~clr_ev) | set_ev;
      if (we) begin
        case (off)
          A_DATA:  out_q     <= merge(out_q, bus.iomem_wdata, bus.iomem_wstrb);
          A_OEB:   oeb_q     <= merge(oeb_q, bus.iomem_wdata, bus.iomem_wstrb);
          A_PU:    pu_q      <= merge(pu_q, bus.iomem_wdata, bus.iomem_wstrb);
          A_PD:    pd_q      <= merge(pd_q, bus.iomem_wdata, bus.iomem_wstrb);
          A_RISE:  rise_en_q <= merge(rise_en_q, bus.iomem_wdata, bus.iomem_wstrb);
          A_FALL:  fall_en_q <= merge(fall_en_q, bus.iomem_wdata, bus.iomem_wstrb);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      filt_d <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      filt_d <= filt;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) filt <= '0;
        else         filt <= sync;
      end
    end else begin : g_filt
      localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] cnt [NUM_PINS];

      // Any return to the accepted level restarts the stability count.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          filt <= '0;
          for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_PINS; i++) begin
            if (sync[i] == filt[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              filt[i] <= sync[i];
              cnt[i]  <= '0;
            end else if (cnt[i] != {CNT_W{1'b1}}) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_picosoc_gpio.sv
// Directed bench for picosoc_gpio: one instance without debounce, one with a
// 4-cycle debounce, sharing clock and reset.
module tb_picosoc_gpio;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  picosoc_gpio_if bus0();
  picosoc_gpio_if bus4();

  logic        valid_d [2];
  logic [3:0]  wstrb_d [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        ready_d [2];
  logic [31:0] rdata_d [2];

  assign bus0.iomem_valid = valid_d[0];
  assign bus0.iomem_wstrb = wstrb_d[0];
  assign bus0.iomem_addr  = addr_d[0];
  assign bus0.iomem_wdata = wdata_d[0];
  assign ready_d[0]       = bus0.iomem_ready;
  assign rdata_d[0]       = bus0.iomem_rdata;
  assign bus4.iomem_valid = valid_d[1];
  assign bus4.iomem_wstrb = wstrb_d[1];
  assign bus4.iomem_addr  = addr_d[1];
  assign bus4.iomem_wdata = wdata_d[1];
  assign ready_d[1]       = bus4.iomem_ready;
  assign rdata_d[1]       = bus4.iomem_rdata;

  logic [7:0] gpio0_in, gpio0_out, gpio0_oeb, gpio0_pu, gpio0_pd;
  logic [7:0] gpio4_in, gpio4_out, gpio4_oeb, gpio4_pu, gpio4_pd;
  logic       irq0, irq4;

  picosoc_gpio #(.NUM_PINS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .BASE_SEL(8'h07)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave),
    .gpio_in(gpio0_in), .gpio_out(gpio0_out), .gpio_oeb(gpio0_oeb),
    .gpio_pu(gpio0_pu), .gpio_pd(gpio0_pd), .irq(irq0)
  );

  picosoc_gpio #(.NUM_PINS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BASE_SEL(8'h07)) u_dut4 (
    .clk(clk), .resetn(resetn), .bus(bus4.slave),
    .gpio_in(gpio4_in), .gpio_out(gpio4_out), .gpio_oeb(gpio4_oeb),
    .gpio_pu(gpio4_pu), .gpio_pd(gpio4_pd), .irq(irq4)
  );

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] page(input logic [7:0] off);
    page = {8'h07, 16'h0000, off};
  endfunction

  task automatic bus_start(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    addr_d[d]  = a;
    wstrb_d[d] = s;
    wdata_d[d] = w;
    valid_d[d] = 1'b1;
  endtask

  task automatic bus_finish(input int d, output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (ready_d[d]) begin
        ok = 1'b1;
        rd = rdata_d[d];
      end
    end
    valid_d[d] = 1'b0;
  endtask

  task automatic bus_xfer(input int d, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] w, output logic [31:0] rd);
    logic ok;
    @(negedge clk);
    bus_start(d, a, s, w);
    bus_finish(d, rd, ok);
    chk("bus_ready", {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [22];

  initial begin
    logic [31:0] rd;
    logic ok;

    for (int d = 0; d < 2; d++) begin
      valid_d[d] = 1'b0; wstrb_d[d] = '0; addr_d[d] = '0; wdata_d[d] = '0;
    end
    gpio0_in = '0;
    gpio4_in = '0;

    // off, wstrb, wdata, expected rdata (pre-write value on writes)
    vecs[0]  = '{8'h04, 4'h0, 32'h0,        32'hFF};
    vecs[1]  = '{8'h00, 4'h0, 32'h0,        32'h00};
    vecs[2]  = '{8'h00, 4'h1, 32'h0000A5C3, 32'h00};
    vecs[3]  = '{8'h1C, 4'h0, 32'h0,        32'hC3};
    vecs[4]  = '{8'h1C, 4'hF, 32'h000000FF, 32'hC3};
    vecs[5]  = '{8'h1C, 4'h0, 32'h0,        32'hC3};
    vecs[6]  = '{8'h08, 4'hF, 32'h0000005A, 32'h00};
    vecs[7]  = '{8'h08, 4'h2, 32'h0000FF00, 32'h5A};
    vecs[8]  = '{8'h08, 4'h0, 32'h0,        32'h5A};
    vecs[9]  = '{8'h0C, 4'h0, 32'h0000003C, 32'h00};
    vecs[10] = '{8'h0C, 4'h1, 32'h00000083, 32'h00};
    vecs[11] = '{8'h0C, 4'h0, 32'h0,        32'h83};
    vecs[12] = '{8'h04, 4'h1, 32'h0000000F, 32'hFF};
    vecs[13] = '{8'h04, 4'h0, 32'h0,        32'h0F};
    vecs[14] = '{8'h04, 4'h2, 32'hFFFFFF00, 32'h0F};
    vecs[15] = '{8'h04, 4'h0, 32'h0,        32'h0F};
    vecs[16] = '{8'h40, 4'h0, 32'h0,        32'h00};
    vecs[17] = '{8'h40, 4'hF, 32'hFFFFFFFF, 32'h00};
    vecs[18] = '{8'h04, 4'h0, 32'h0,        32'h0F};
    vecs[19] = '{8'h10, 4'h0, 32'h0,        32'h00};
    vecs[20] = '{8'h14, 4'h0, 32'h0,        32'h00};
    vecs[21] = '{8'h18, 4'h0, 32'h0,        32'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready_d[0]}, 32'd0);
    chk("rst_rdata", rdata_d[0], 32'd0);
    chk("rst_irq", {31'b0, irq0}, 32'd0);
    chk("rst_out", {24'b0, gpio0_out}, 32'h00);
    chk("rst_oeb", {24'b0, gpio0_oeb}, 32'hFF);
    chk("rst_pu", {24'b0, gpio0_pu}, 32'h00);
    chk("rst_pd", {24'b0, gpio0_pd}, 32'h00);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      bus_xfer(0, page(vecs[i].off), vecs[i].wstrb, vecs[i].wdata, rd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (i == 2) chk("out_at_ready", {24'b0, gpio0_out}, 32'hC3);
    end
    chk("port_out", {24'b0, gpio0_out}, 32'hC3);
    chk("port_oeb", {24'b0, gpio0_oeb}, 32'h0F);
    chk("port_pu", {24'b0, gpio0_pu}, 32'h5A);
    chk("port_pd", {24'b0, gpio0_pd}, 32'h83);

    // Rise on pin 0: irq appears three edges after the sampling edge.
    bus_xfer(0, page(8'h10), 4'hF, 32'h1, rd);
    @(negedge clk);
    gpio0_in[0] = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_k2", {31'b0, irq0}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_k3", {31'b0, irq0}, 32'd1);
    bus_xfer(0, page(8'h18), 4'h0, 32'h0, rd);
    chk("status_rise", rd, 32'h01);
    bus_xfer(0, page(8'h18), 4'hF, 32'h1, rd);
    chk("w1c_rdata", rd, 32'h01);
    chk("irq_w1c", {31'b0, irq0}, 32'd0);

    // W1C landing on the same edge as a new set event: the set wins.
    bus_xfer(0, page(8'h14), 4'hF, 32'h1, rd);
    @(negedge clk);
    gpio0_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("irq_fall", {31'b0, irq0}, 32'd1);
    @(negedge clk);
    gpio0_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_start(0, page(8'h18), 4'hF, 32'h1);
    bus_finish(0, rd, ok);
    chk("collide_ready", {31'b0, ok}, 32'd1);
    chk("collide_rdata", rd, 32'h01);
    chk("collide_irq", {31'b0, irq0}, 32'd1);
    @(posedge clk);
    #1;
    chk("collide_irq_hold", {31'b0, irq0}, 32'd1);
    bus_xfer(0, page(8'h10), 4'hF, 32'h0, rd);
    bus_xfer(0, page(8'h18), 4'h0, 32'h0, rd);
    chk("en_clear_keeps", rd, 32'h01);
    bus_xfer(0, page(8'h18), 4'hF, 32'hFF, rd);
    chk("irq_final_clear", {31'b0, irq0}, 32'd0);

    // Debounce: a 3-cycle pulse is rejected, a sustained level is accepted.
    bus_xfer(1, page(8'h10), 4'hF, 32'h2, rd);
    @(negedge clk);
    gpio4_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    gpio4_in[1] = 1'b0;
    repeat (10) @(posedge clk);
    bus_xfer(1, page(8'h00), 4'h0, 32'h0, rd);
    chk("glitch_data", rd, 32'h00);
    bus_xfer(1, page(8'h18), 4'h0, 32'h0, rd);
    chk("glitch_status", rd, 32'h00);
    @(negedge clk);
    gpio4_in[1] = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("deb_irq_k5", {31'b0, irq4}, 32'd0);
    @(posedge clk);
    #1;
    chk("deb_irq_k6", {31'b0, irq4}, 32'd1);
    bus_xfer(1, page(8'h00), 4'h0, 32'h0, rd);
    chk("deb_data", rd, 32'h02);

    // Request outside this block's page gets no response and no side effect.
    @(negedge clk);
    bus_start(0, 32'h0300_0000, 4'hF, 32'h0);
    bus_finish(0, rd, ok);
    chk("unsel_ready", {31'b0, ok}, 32'd0);
    chk("unsel_out", {24'b0, gpio0_out}, 32'hC3);

    // Reset during a pending write to OEB.
    @(negedge clk);
    bus_start(0, page(8'h04), 4'hF, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready_d[0]}, 32'd0);
    chk("mid_rst_out", {24'b0, gpio0_out}, 32'h00);
    chk("mid_rst_pu", {24'b0, gpio0_pu}, 32'h00);
    chk("mid_rst_pd", {24'b0, gpio0_pd}, 32'h83 & 32'h00);
    @(posedge clk);
    #1;
    chk("mid_rst_oeb", {24'b0, gpio0_oeb}, 32'hFF);
    chk("mid_rst_irq4", {31'b0, irq4}, 32'd0);
    @(negedge clk);
    valid_d[0] = 1'b0;
    resetn = 1'b1;
    bus_xfer(0, page(8'h04), 4'h0, 32'h0, rd);
    chk("post_rst_oeb", rd, 32'hFF);
    bus_xfer(0, page(8'h10), 4'h0, 32'h0, rd);
    chk("post_rst_rise_en", rd, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
